// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command-frame parser.
//   - parser state encoding (localparams + enum built on them)
//   - default start-of-frame marker
//   - checksum width
//   - helper deriving the length-field width from the maximum payload size
package uart_frame_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_CMD     = 3'd1;
  localparam logic [2:0] ENC_LEN     = 3'd2;
  localparam logic [2:0] ENC_PAYLOAD = 3'd3;
  localparam logic [2:0] ENC_CHK     = 3'd4;
  localparam logic [2:0] ENC_HOLD    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ENC_IDLE,
    S_CMD     = ENC_CMD,
    S_LEN     = ENC_LEN,
    S_PAYLOAD = ENC_PAYLOAD,
    S_CHK     = ENC_CHK,
    S_HOLD    = ENC_HOLD
  } state_e;

  localparam logic [7:0] DEF_SOF = 8'hA5;
  localparam int         CHK_W   = 8;

  // Width needed to hold a length of 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/frame_payload_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port memory.
//   clk, rst  : clock, synchronous active-high reset (clears read register only)
//   we_i, waddr_i, wdata_i : write port
//   raddr_i   : read index; rdata_o is registered (1-cycle latency)
//   Reads at raddr_i >= DEPTH return 8'h00. Writes beyond DEPTH are ignored.
module frame_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  // Rounded up to a power of two so the sliced index is always in range;
  // entries at or above DEPTH are never written nor read.
  logic [7:0] mem_q [0:(1<<IW)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < DEPTH_A)) mem_q[waddr_i[IW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)                       rdata_q <= 8'h00;
    else if (raddr_i < DEPTH_A)    rdata_q <= mem_q[raddr_i[IW-1:0]];
    else                           rdata_q <= 8'h00;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Command-frame extractor behind the UART receiver.
// Frame: SOF, CMD, LEN, LEN payload bytes, CHK (8-bit sum of CMD+LEN+payload).
//   clk, rst            : clock, synchronous active-high reset
//   rx_data, rx_valid   : received byte stream (strobe per byte)
//   cmd_valid/cmd_ready : handshake for a validated frame held in HOLD
//   cmd_id, cmd_len     : CMD byte and payload length of the held frame
//   pl_addr -> pl_data  : registered payload read port (1-cycle latency)
//   err_chk/len/timeout/drop : one-cycle error strobes
//   frame_cnt           : accepted frames, saturating
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = DEF_SOF,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         LW             = len_w(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_id,
  output logic [LW-1:0] cmd_len,
  input  logic [LW-1:0] pl_addr,
  output logic [7:0]    pl_data,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_drop,
  output logic [15:0]   frame_cnt
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);

  state_e             state_q, state_d;
  logic [7:0]         cmd_id_q, cmd_id_d;
  logic [LW-1:0]      cmd_len_q, cmd_len_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic [CHK_W-1:0]   sum_q, sum_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               e_chk_q, e_chk_d, e_len_q, e_len_d;
  logic               e_tmo_q, e_tmo_d, e_drop_q, e_drop_d;
  logic               buf_we;
  logic               in_frame;

  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);

  always_comb begin
    state_d   = state_q;
    cmd_id_d  = cmd_id_q;
    cmd_len_d = cmd_len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    fcnt_d    = fcnt_q;
    e_chk_d   = 1'b0;
    e_len_d   = 1'b0;
    e_tmo_d   = 1'b0;
    e_drop_d  = 1'b0;
    buf_we    = 1'b0;
    // Counter only runs between bytes inside a frame; a byte always restarts it.
    tmo_d     = (in_frame && !rx_valid) ? tmo_q + TW'(1) : '0;

    if (in_frame && !rx_valid && (tmo_q == TMO_LAST)) begin
      // A byte on the expiry cycle takes the other branch below, so it wins.
      state_d = S_IDLE;
      e_tmo_d = 1'b1;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (rx_valid && (rx_data == SOF_BYTE)) state_d = S_CMD;
        S_CMD: if (rx_valid) begin
          cmd_id_d = rx_data;
          sum_d    = rx_data;
          state_d  = S_LEN;
        end
        S_LEN: if (rx_valid) begin
          if (rx_data > MAX_B) begin
            e_len_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cmd_len_d = LW'(rx_data);
            sum_d     = sum_q + rx_data;
            idx_d     = '0;
            state_d   = (rx_data == 8'h00) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (rx_valid) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_data;
          idx_d  = idx_q + LW'(1);
          if (idx_q == cmd_len_q - LW'(1)) state_d = S_CHK;
        end
        S_CHK: if (rx_valid) begin
          if (rx_data == sum_q) begin
            state_d = S_HOLD;
            if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
          end else begin
            e_chk_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_HOLD: begin
          // Nothing is buffered behind a held frame: every byte here is lost.
          e_drop_d = rx_valid;
          if (cmd_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_id_q  <= '0;
      cmd_len_q <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      fcnt_q    <= '0;
      e_chk_q   <= 1'b0;
      e_len_q   <= 1'b0;
      e_tmo_q   <= 1'b0;
      e_drop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_id_q  <= cmd_id_d;
      cmd_len_q <= cmd_len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      fcnt_q    <= fcnt_d;
      e_chk_q   <= e_chk_d;
      e_len_q   <= e_len_d;
      e_tmo_q   <= e_tmo_d;
      e_drop_q  <= e_drop_d;
    end
  end

  frame_payload_buf #(.DEPTH(MAX_LEN), .AW(LW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (rx_data),
    .raddr_i (pl_addr),
    .rdata_o (pl_data)
  );

  assign cmd_valid   = (state_q == S_HOLD);
  assign cmd_id      = cmd_id_q;
  assign cmd_len     = cmd_len_q;
  assign err_chk     = e_chk_q;
  assign err_len     = e_len_q;
  assign err_timeout = e_tmo_q;
  assign err_drop    = e_drop_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 20;
  localparam logic [7:0] SOF     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_valid, cmd_ready = 1'b0;
  logic [7:0] cmd_id;
  logic [4:0] cmd_len;
  logic [4:0] pl_addr = 5'd0;
  logic [7:0] pl_data;
  logic       err_chk, err_len, err_timeout, err_drop;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .pl_addr(pl_addr), .pl_data(pl_data), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout), .err_drop(err_drop), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0, n_mis = 0;
  // observed pulse-cycle counts vs. model expectations
  int n_echk = 0, n_elen = 0, n_etmo = 0, n_edrop = 0;
  int x_echk = 0, x_elen = 0, x_etmo = 0, x_edrop = 0;
  int x_fcnt = 0;
  logic [7:0] pq[$];

  always @(negedge clk) begin
    if (err_chk)     n_echk++;
    if (err_len)     n_elen++;
    if (err_timeout) n_etmo++;
    if (err_drop)    n_edrop++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  function automatic logic [7:0] rnd_not_sof();
    logic [7:0] b = 8'($urandom);
    return (b == SOF) ? 8'h00 : b;
  endfunction

  // Reference checksum: plain modular sum of CMD, LEN and payload.
  function automatic logic [7:0] ref_sum(input logic [7:0] id, input logic [7:0] lb);
    int s = id + lb;
    foreach (pq[i]) s += pq[i];
    return 8'(s % 256);
  endfunction

  task automatic check_errs(input string tag);
    tick(); tick();
    check({tag, "_echk"},  n_echk,  x_echk);
    check({tag, "_elen"},  n_elen,  x_elen);
    check({tag, "_etmo"},  n_etmo,  x_etmo);
    check({tag, "_edrop"}, n_edrop, x_edrop);
  endtask

  // Sends SOF/CMD/LEN[/payload/CHK]; pq must hold lb bytes when lb <= MAX_LEN.
  task automatic send_frame(input logic [7:0] id, input logic [7:0] lb,
                            input logic [7:0] c, output bit acc);
    acc = 1'b0;
    send(SOF); gap(); send(id); gap(); send(lb);
    if (lb > MAX_LEN) begin x_elen++; return; end
    foreach (pq[i]) begin gap(); send(pq[i]); end
    gap();
    check("valid_before_chk", cmd_valid, 0);
    send(c);
    acc = (c == ref_sum(id, lb));
    if (acc) x_fcnt = (x_fcnt == 65535) ? 65535 : x_fcnt + 1;
    else     x_chk_inc();
    check("valid_after_chk", cmd_valid, acc);
  endtask

  task automatic x_chk_inc();
    x_echk++;
  endtask

  // Inspect and release a held frame; ndrop bytes are sent while holding.
  task automatic hold_release(input logic [7:0] id, input logic [7:0] lb,
                              input int ndrop, input bit coincide);
    check("hold_id", cmd_id, id);
    check("hold_len", cmd_len, lb);
    check("hold_fcnt", frame_cnt, x_fcnt);
    for (int k = 0; k < ndrop; k++) begin
      send((k == 0) ? 8'h55 : SOF);
      x_edrop++;
    end
    foreach (pq[i]) begin
      pl_addr = 5'(i); tick();
      check("hold_pl", pl_data, pq[i]);
    end
    pl_addr = 5'($urandom_range(MAX_LEN, 31)); tick();
    check("pl_oob", pl_data, 0);
    check("hold_valid", cmd_valid, 1);
    check("hold_id2", cmd_id, id);
    check("hold_len2", cmd_len, lb);
    cmd_ready = 1'b1;
    if (coincide) begin rx_data = SOF; rx_valid = 1'b1; x_edrop++; end
    tick();
    cmd_ready = 1'b0; rx_valid = 1'b0;
    check("released", cmd_valid, 0);
  endtask

  task automatic load_pq(input int n);
    pq.delete();
    for (int i = 0; i < n; i++) pq.push_back(8'($urandom));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit acc;
    bit seen;
    int k;
    logic [7:0] id, lb, c;

    // reset state
    tick(); tick();
    check("rst_valid", cmd_valid, 0);
    check("rst_id", cmd_id, 0);
    check("rst_len", cmd_len, 0);
    check("rst_pl", pl_data, 0);
    check("rst_fcnt", frame_cnt, 0);
    rst = 1'b0; tick();

    // good frame A5 10 02 11 22 45
    pq = '{8'h11, 8'h22};
    send_frame(8'h10, 8'h02, 8'h45, acc);
    check("good_acc", acc, 1);
    hold_release(8'h10, 8'h02, 0, 0);
    check_errs("good");

    // checksum error, then zero-length frame
    send_frame(8'h10, 8'h02, 8'h46, acc);
    check_errs("badchk");
    pq.delete();
    send_frame(8'h20, 8'h00, 8'h20, acc);
    hold_release(8'h20, 8'h00, 0, 0);
    check_errs("zlen");

    // length error followed by a valid frame (LEN == MAX_LEN boundary)
    send_frame(8'h10, 8'h11, 8'h00, acc);
    check_errs("badlen");
    load_pq(MAX_LEN);
    send_frame(8'h33, 8'(MAX_LEN), ref_sum(8'h33, 8'(MAX_LEN)), acc);
    hold_release(8'h33, 8'(MAX_LEN), 0, 0);
    check_errs("maxlen");

    // timeout: pulse exactly TMO cycles after the last byte strobe
    send(SOF); send(8'h10);
    seen = 1'b0;
    for (k = 1; k <= TMO + 5; k++) begin
      tick();
      if (err_timeout) begin seen = 1'b1; break; end
    end
    check("tmo_seen", seen, 1);
    check("tmo_delay", k, TMO);
    x_etmo++;
    check_errs("tmo");

    // byte on the expiry cycle wins
    send(SOF); send(8'h10);
    repeat (TMO - 1) tick();
    send(8'h00);
    send(8'h10);
    check("expiry_byte_valid", cmd_valid, 1);
    x_fcnt++;
    pq.delete();
    hold_release(8'h10, 8'h00, 0, 0);
    check_errs("expiry");

    // hold/drop: 55 and A5 dropped, plus byte coincident with handshake
    pq = '{8'hDE, 8'hAD, 8'hBE};
    send_frame(8'h42, 8'h03, ref_sum(8'h42, 8'h03), acc);
    hold_release(8'h42, 8'h03, 2, 1);
    check_errs("drop");

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) begin send(rnd_not_sof()); gap(); end
      id = 8'($urandom);
      if (kind >= 8) begin
        lb = 8'($urandom_range(MAX_LEN + 1, 255));
        pq.delete();
        c = 8'h00;
      end else begin
        lb = 8'($urandom_range(0, MAX_LEN));
        load_pq(int'(lb));
        c = ref_sum(id, lb);
        if (kind >= 6) c = c + 8'($urandom_range(1, 255));
      end
      send_frame(id, lb, c, acc);
      if (acc) hold_release(id, lb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      check_errs("rnd");
    end

    // reset mid-frame
    send(SOF); send(8'h10); send(8'h02); send(8'h11);
    rst = 1'b1; tick();
    check("mrst_valid", cmd_valid, 0);
    check("mrst_id", cmd_id, 0);
    check("mrst_len", cmd_len, 0);
    check("mrst_pl", pl_data, 0);
    check("mrst_fcnt", frame_cnt, 0);
    rst = 1'b0; x_fcnt = 0; tick();
    pq = '{8'h01, 8'h02};
    send_frame(8'h07, 8'h02, ref_sum(8'h07, 8'h02), acc);
    hold_release(8'h07, 8'h02, 0, 0);
    check_errs("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
